// File: rtl/router_pkt_reg.sv
// Packet register stage between a router source port and its channel FIFOs: registers each byte,
// decodes the destination, checks the trailing check byte. Optional length check: ROUTER_PKT_LEN_CHK_EN.
module router_pkt_reg #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int NUM_CH   = 3,
  parameter int CHK_MODE = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  output logic              busy,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [ADDR_W-1:0] dest_addr,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              len_err
);
  localparam int LEN_W = DATA_W - ADDR_W;
  localparam logic [ADDR_W:0] NUM_CH_W = NUM_CH[ADDR_W:0];

  typedef enum logic [1:0] {IDLE, LOAD, DROP, CHECK} state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] chk;
  logic              dropped;
  logic              accept;
  logic              hdr_legal;
  logic              len_bad;

  function automatic logic [DATA_W-1:0] acc_next(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] d);
    if (CHK_MODE == 1) return a + d;
    else               return a ^ d;
  endfunction

`ifdef ROUTER_PKT_LEN_CHK_EN
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] count;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign len_bad = (count != len);
`else
  assign len_bad = 1'b0;
`endif

  assign busy      = fifo_full | (state == CHECK);
  assign accept    = !busy && ((state == LOAD) || (state == DROP) ||
                               ((state == IDLE) && pkt_valid));
  assign hdr_legal = ({1'b0, data_in[ADDR_W-1:0]} < NUM_CH_W);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= IDLE;
      dout          <= '0;
      dout_valid    <= 1'b0;
      dest_addr     <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
      len_err       <= 1'b0;
      acc           <= '0;
      chk           <= '0;
      dropped       <= 1'b0;
`ifdef ROUTER_PKT_LEN_CHK_EN
      len           <= '0;
      count         <= '0;
`endif
    end else begin
      dout_valid  <= 1'b0;
      parity_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dest_addr <= data_in[ADDR_W-1:0];
            acc       <= data_in;
            err       <= 1'b0;
            len_err   <= 1'b0;
`ifdef ROUTER_PKT_LEN_CHK_EN
            len       <= data_in[DATA_W-1:ADDR_W];
            count     <= '0;
`endif
            if (hdr_legal) begin
              dout       <= data_in;
              dout_valid <= 1'b1;
              dropped    <= 1'b0;
              state      <= LOAD;
            end else begin
              dropped <= 1'b1;
              state   <= DROP;
            end
          end
        end
        LOAD, DROP: begin
          if (accept) begin
            // Dropped packets are still consumed byte by byte, just never forwarded.
            if (state == LOAD) begin
              dout       <= data_in;
              dout_valid <= 1'b1;
            end
            if (pkt_valid) begin
              acc <= acc_next(acc, data_in);
`ifdef ROUTER_PKT_LEN_CHK_EN
              count <= sat_inc(count);
`endif
            end else begin
              chk           <= data_in;
              low_pkt_valid <= 1'b1;
              state         <= CHECK;
            end
          end
        end
        CHECK: begin
          err           <= (acc != chk) | dropped | len_bad;
          len_err       <= len_bad;
          parity_done   <= 1'b1;
          low_pkt_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_router_pkt_reg.sv
// Bench for router_pkt_reg: directed packets plus random traffic on a parity and a checksum
// instance, compared against a packet-level reference model.
module tb_router_pkt_reg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int NUM_CH = 3;

  logic              clock = 1'b0;
  logic              resetn;
  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;

  logic              busy0, busy1;
  logic [DATA_W-1:0] dout0, dout1;
  logic              dout_valid0, dout_valid1;
  logic [ADDR_W-1:0] dest_addr0, dest_addr1;
  logic              parity_done0, parity_done1;
  logic              low_pkt_valid0, low_pkt_valid1;
  logic              err0, err1;
  logic              len_err0, len_err1;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] last_byte = 8'h00;
  bit         mon_on = 1'b0;

  router_pkt_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CHK_MODE(0)) dut0 (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .busy(busy0), .dout(dout0), .dout_valid(dout_valid0),
    .dest_addr(dest_addr0), .parity_done(parity_done0), .low_pkt_valid(low_pkt_valid0),
    .err(err0), .len_err(len_err0));

  router_pkt_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CHK_MODE(1)) dut1 (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .busy(busy1), .dout(dout1), .dout_valid(dout_valid1),
    .dest_addr(dest_addr1), .parity_done(parity_done1), .low_pkt_valid(low_pkt_valid1),
    .err(err1), .len_err(len_err1));

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output stream: a byte accepted at one edge must appear exactly once after it; otherwise dout holds.
  always @(negedge clock) begin
    if (mon_on) begin
      check_val("dout_valid0", dout_valid0, exp_q.size() != 0);
      check_val("dout_valid1", dout_valid1, exp_q.size() != 0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      check_val("dout0", dout0, last_byte);
      check_val("dout1", dout1, last_byte);
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy0"}, busy0, 0);
    check_val({tag, "_busy1"}, busy1, 0);
    check_val({tag, "_pdone0"}, parity_done0, 0);
    check_val({tag, "_pdone1"}, parity_done1, 0);
    check_val({tag, "_low0"}, low_pkt_valid0, 0);
    check_val({tag, "_low1"}, low_pkt_valid1, 0);
    check_val({tag, "_err0"}, err0, 0);
    check_val({tag, "_err1"}, err1, 0);
    check_val({tag, "_lenerr0"}, len_err0, 0);
    check_val({tag, "_lenerr1"}, len_err1, 0);
    check_val({tag, "_addr0"}, dest_addr0, 0);
    check_val({tag, "_addr1"}, dest_addr1, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 with reset released.
  task automatic apply_reset(input int cycles);
    resetn    = 1'b0;
    fifo_full = 1'b0;
    pkt_valid = 1'($urandom_range(0, 1));
    data_in   = 8'($urandom);
    repeat (cycles) @(posedge clock);
    #1 last_byte = 8'h00;
    @(negedge clock);
    check_idle_outputs("reset");
    @(posedge clock);
    #1 resetn = 1'b1;
    pkt_valid = 1'b0;
  endtask

  // Holds one byte on data_in until accepted; stalls < 0 picks a random fifo_full burst.
  task automatic drive_byte(input logic [7:0] b, input logic pv, input int stalls,
                            input bit fwd, input bit mid_pkt);
    int n;
    n = (stalls >= 0) ? stalls : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    data_in   = b;
    pkt_valid = pv;
    for (int i = 0; i <= n; i++) begin
      fifo_full = (i < n);
      @(negedge clock);
      check_val("busy0", busy0, fifo_full);
      check_val("busy1", busy1, fifo_full);
      if (mid_pkt) begin
        check_val("mid_err0", err0, 0);
        check_val("mid_err1", err1, 0);
        check_val("mid_lenerr0", len_err0, 0);
        check_val("mid_pdone0", parity_done0, 0);
        check_val("mid_low0", low_pkt_valid0, 0);
      end
      @(posedge clock);
      #1;
    end
    fifo_full = 1'b0;
    if (fwd) begin
      exp_q.push_back(b);
      last_byte = b;
    end
  endtask

  // Sends header, pay_q and check byte; rst_after >= 0 resets before payload byte rst_after.
  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] ck,
                          input int stall_idx, input int rst_after);
    bit         legal, le, e0, e1;
    logic [7:0] x, s;
    legal = (int'(hdr[1:0]) < NUM_CH);
    x = hdr;
    s = hdr;
    foreach (pay_q[i]) begin
      x = x ^ pay_q[i];
      s = s + pay_q[i];
    end
`ifdef ROUTER_PKT_LEN_CHK_EN
    le = (pay_q.size() != int'(hdr[7:2]));
`else
    le = 1'b0;
`endif
    e0 = !legal || (x != ck) || le;
    e1 = !legal || (s != ck) || le;

    drive_byte(hdr, 1'b1, -1, legal, 1'b0);
    foreach (pay_q[i]) begin
      if (rst_after == i) begin
        apply_reset(1);
        return;
      end
      drive_byte(pay_q[i], 1'b1, (i == stall_idx) ? 3 : -1, legal, 1'b1);
    end
    drive_byte(ck, 1'b0, -1, legal, 1'b1);
    // Junk offered during the check cycle must be ignored.
    pkt_valid = 1'($urandom_range(0, 1));
    data_in   = 8'($urandom);
    @(negedge clock);
    check_val("chk_busy0", busy0, 1);
    check_val("chk_busy1", busy1, 1);
    check_val("chk_low0", low_pkt_valid0, 1);
    check_val("chk_low1", low_pkt_valid1, 1);
    check_val("chk_pdone0", parity_done0, 0);
    @(posedge clock);
    #1 pkt_valid = 1'b0;
    @(negedge clock);
    check_val("pdone0", parity_done0, 1);
    check_val("pdone1", parity_done1, 1);
    check_val("end_low0", low_pkt_valid0, 0);
    check_val("end_low1", low_pkt_valid1, 0);
    check_val("err0", err0, e0);
    check_val("err1", err1, e1);
    check_val("len_err0", len_err0, le);
    check_val("len_err1", len_err1, le);
    check_val("dest_addr0", dest_addr0, hdr[1:0]);
    check_val("dest_addr1", dest_addr1, hdr[1:0]);
    check_val("idle_busy0", busy0, 0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check_val("pdone_pulse0", parity_done0, 0);
    check_val("pdone_pulse1", parity_done1, 0);
    check_val("err_hold0", err0, e0);
    check_val("err_hold1", err1, e1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int npay, r, ra;
    logic [5:0] len;
    logic [1:0] addr;
    logic [7:0] hdr, x, s, ck;

    resetn = 1'b0;
    pkt_valid = 1'b0;
    data_in = '0;
    fifo_full = 1'b0;
    apply_reset(2);
    mon_on = 1'b1;

    pay_q = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0D, 8'h0D, -1, -1);   // parity good, sum bad
    send_pkt(8'h0D, 8'h0E, -1, -1);   // both bad
    send_pkt(8'h0D, 8'h0D, 1, -1);    // 3-cycle stall on 22
    send_pkt(8'h0F, 8'h0D, -1, -1);   // illegal address, dropped
    send_pkt(8'h0D, 8'h0D, -1, 2);    // reset after second payload byte
    send_pkt(8'h0D, 8'h0D, -1, -1);
    send_pkt(8'h0D, 8'h73, -1, -1);   // sum good, parity bad
    pay_q = '{8'h11, 8'h22};
    send_pkt(8'h0D, 8'h3E, -1, -1);   // short packet, parity good

    for (int p = 0; p < 200; p++) begin
      npay = $urandom_range(0, 5);
      addr = 2'($urandom_range(0, 3));
      len  = ($urandom_range(0, 3) != 0) ? 6'(npay) : 6'($urandom_range(0, 63));
      hdr  = {len, addr};
      pay_q.delete();
      x = hdr;
      s = hdr;
      for (int i = 0; i < npay; i++) begin
        pay_q.push_back(8'($urandom));
        x = x ^ pay_q[i];
        s = s + pay_q[i];
      end
      r  = $urandom_range(0, 2);
      ck = (r == 0) ? x : (r == 1) ? s : 8'($urandom);
      ra = ((npay > 0) && ($urandom_range(0, 19) == 0)) ? int'($urandom_range(0, npay - 1)) : -1;
      send_pkt(hdr, ck, -1, ra);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
